// File: rtl/link_pkg.sv
// Shared definitions for the transmit link FIFO: FSM state encoding and
// overflow-handling mode selectors.
package link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } link_state_e;

    localparam int unsigned OVF_DROP_NEWEST     = 0;
    localparam int unsigned OVF_OVERWRITE_OLDEST = 1;

endpackage : link_pkg

// File: rtl/link_fifo_mem.sv
// WIDTH x DEPTH storage for the link FIFO: synchronous write, combinational
// read of the entry addressed by the head pointer.
module link_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_dot4x,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_dot4x) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : link_fifo_mem

// File: rtl/tx_link_fifo.sv
// Transmit link FIFO: queues words and hands them to a consumer one at a time,
// ignoring the consumer's busy level for HOLDOFF cycles after every send.
module tx_link_fifo
    import link_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned HOLDOFF  = 4,
    parameter int unsigned OVF_MODE = OVF_DROP_NEWEST
) (
    input  logic                     clk_dot4x,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_new,
    input  logic                     flush,
    input  logic                     out_busy,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_new,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     ovf_clear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    link_state_e      state, state_nx;
    logic [HW-1:0]    hold_cnt, hold_nx;
    logic [AW-1:0]    head, tail;
    logic [WIDTH-1:0] rd_data;

    logic pop, push, lost, wr_en, head_adv;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign pop  = (state == ST_IDLE) && !empty && !out_busy && !flush;
    assign push = in_new && !flush;
    // A push into a full FIFO without a coincident pop loses a word in either mode.
    assign lost = push && full && !pop;
    assign wr_en    = push && (!full || pop || (OVF_MODE == OVF_OVERWRITE_OLDEST));
    assign head_adv = pop || (lost && (OVF_MODE == OVF_OVERWRITE_OLDEST));

    link_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_dot4x (clk_dot4x),
        .wr_en     (wr_en),
        .wr_addr   (tail),
        .wr_data   (in_data),
        .rd_addr   (head),
        .rd_data   (rd_data)
    );

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        unique case (state)
            ST_IDLE: begin
                if (pop) begin
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                if (HOLDOFF > 1) begin
                    state_nx = ST_HOLD;
                    hold_nx  = HW'(HOLDOFF - 1);
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Leave as the counter reaches zero so a new send can follow one IDLE cycle later.
                hold_nx = hold_cnt - 1'b1;
                if (hold_cnt <= HW'(1)) begin
                    state_nx = ST_IDLE;
                    hold_nx  = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                hold_nx  = '0;
            end
        endcase
        if (flush) begin
            state_nx = ST_IDLE;
            hold_nx  = '0;
        end
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
        end
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (head_adv) begin
                head <= head + 1'b1;
            end
            if (wr_en) begin
                tail <= tail + 1'b1;
            end
            if (wr_en && !lost && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !(wr_en && !lost)) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_new  <= 1'b0;
        end else begin
            out_new <= pop;
            if (pop) begin
                out_data <= rd_data;
            end
        end
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (lost) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

endmodule : tx_link_fifo

// File: tb/tb_tx_link_fifo.sv
// Directed bench for tx_link_fifo: one instance per overflow mode, driven by
// the same stimulus, with hand-computed expectations.
module tb_tx_link_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_new;
    logic       flush;
    logic       out_busy;
    logic       ovf_clear;

    logic [7:0] od0, od1;
    logic       on0, on1;
    logic [4:0] cnt0, cnt1;
    logic       full0, full1, empty0, empty1, ovf0, ovf1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] q0_d[$];
    logic [7:0] q1_d[$];
    int         q0_c[$];
    int         q1_c[$];

    tx_link_fifo #(.WIDTH(8), .DEPTH(16), .HOLDOFF(4), .OVF_MODE(0)) dut0 (
        .clk_dot4x (clk), .rst_n (rst_n), .in_data (in_data), .in_new (in_new),
        .flush (flush), .out_busy (out_busy), .out_data (od0), .out_new (on0),
        .count (cnt0), .full (full0), .empty (empty0), .overflow (ovf0),
        .ovf_clear (ovf_clear)
    );

    tx_link_fifo #(.WIDTH(8), .DEPTH(16), .HOLDOFF(4), .OVF_MODE(1)) dut1 (
        .clk_dot4x (clk), .rst_n (rst_n), .in_data (in_data), .in_new (in_new),
        .flush (flush), .out_busy (out_busy), .out_data (od1), .out_new (on1),
        .count (cnt1), .full (full1), .empty (empty1), .overflow (ovf1),
        .ovf_clear (ovf_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (on0) begin q0_d.push_back(od0); q0_c.push_back(cyc); end
        if (on1) begin q1_d.push_back(od1); q1_c.push_back(cyc); end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        q0_d.delete(); q1_d.delete(); q0_c.delete(); q1_c.delete();
    endtask

    task automatic push_word(input logic [7:0] d);
        in_data = d;
        in_new  = 1'b1;
        step(1);
        in_new  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_new = 1'b0; flush = 1'b0;
        out_busy = 1'b0; ovf_clear = 1'b0;

        // reset values
        #12;
        check_val("rst_count0", cnt0, 0);
        check_val("rst_empty0", empty0, 1);
        check_val("rst_full0", full0, 0);
        check_val("rst_ovf0", ovf0, 0);
        check_val("rst_new0", on0, 0);
        check_val("rst_data1", od1, 0);

        // single word, pushed on the first edge after reset release
        rst_n = 1'b1;
        push_word(8'hA5);
        check_val("one_count_k", cnt0, 1);
        check_val("one_new_k", on0, 0);
        step(1);
        check_val("one_new0", on0, 1);
        check_val("one_data0", od0, 8'hA5);
        check_val("one_data1", od1, 8'hA5);
        check_val("one_count_k1", cnt0, 0);
        step(1);
        check_val("one_new_off", on0, 0);
        step(6);

        // back-to-back pushes: spacing HOLDOFF+1
        clear_q();
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        step(20);
        check_val("b2b_n0", q0_d.size(), 3);
        check_val("b2b_n1", q1_d.size(), 3);
        if (q0_d.size() == 3) begin
            check_val("b2b_d0", q0_d[0], 8'h11);
            check_val("b2b_d1", q0_d[1], 8'h22);
            check_val("b2b_d2", q0_d[2], 8'h33);
            check_val("b2b_gap01", q0_c[1] - q0_c[0], 5);
            check_val("b2b_gap12", q0_c[2] - q0_c[1], 5);
        end

        // overflow while blocked
        clear_q();
        out_busy = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'(i));
        check_val("ovf_count0", cnt0, 16);
        check_val("ovf_count1", cnt1, 16);
        check_val("ovf_full0", full0, 1);
        check_val("ovf_flag0", ovf0, 1);
        check_val("ovf_flag1", ovf1, 1);
        check_val("ovf_blocked", q0_d.size(), 0);
        ovf_clear = 1'b1;
        step(1);
        ovf_clear = 1'b0;
        check_val("ovf_clr0", ovf0, 0);
        check_val("ovf_clr1", ovf1, 0);
        out_busy = 1'b0;
        step(85);
        check_val("ovf_n0", q0_d.size(), 16);
        check_val("ovf_n1", q1_d.size(), 16);
        if (q0_d.size() == 16 && q1_d.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check_val($sformatf("ovf_drop_%0d", i), q0_d[i], 32'(i));
                check_val($sformatf("ovf_over_%0d", i), q1_d[i], 32'(i + 1));
            end
        end
        check_val("ovf_drain0", cnt0, 0);
        check_val("ovf_drain1", cnt1, 0);

        // push and pop at the same edge while full
        out_busy = 1'b1;
        for (int i = 0; i < 16; i++) push_word(8'(8'h40 + i));
        check_val("pp_pre_count", cnt0, 16);
        check_val("pp_pre_ovf", ovf0, 0);
        out_busy = 1'b0;
        push_word(8'h99);
        out_busy = 1'b1;
        check_val("pp_count0", cnt0, 16);
        check_val("pp_count1", cnt1, 16);
        check_val("pp_ovf0", ovf0, 0);
        check_val("pp_ovf1", ovf1, 0);
        check_val("pp_new0", on0, 1);
        check_val("pp_data1", od1, 8'h40);
        // overflow set beats clear
        ovf_clear = 1'b1;
        push_word(8'h98);
        ovf_clear = 1'b0;
        check_val("setwin0", ovf0, 1);
        check_val("setwin1", ovf1, 1);
        // flush in HOLD aborts holdoff, keeps overflow
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check_val("fl_count0", cnt0, 0);
        check_val("fl_empty1", empty1, 1);
        check_val("fl_ovf0", ovf0, 1);
        ovf_clear = 1'b1;
        out_busy  = 1'b0;
        push_word(8'h5A);
        ovf_clear = 1'b0;
        check_val("fl_ovfclr", ovf0, 0);
        step(1);
        check_val("abort_new0", on0, 1);
        check_val("abort_data0", od0, 8'h5A);
        step(6);

        // flush beats a coincident push
        clear_q();
        out_busy = 1'b1;
        for (int i = 0; i < 5; i++) push_word(8'(8'h60 + i));
        check_val("f5_count", cnt0, 5);
        flush = 1'b1;
        push_word(8'h77);
        flush = 1'b0;
        check_val("f5_count0", cnt0, 0);
        check_val("f5_count1", cnt1, 0);
        check_val("f5_empty0", empty0, 1);
        out_busy = 1'b0;
        step(10);
        check_val("f5_nonew0", q0_d.size(), 0);
        check_val("f5_nonew1", q1_d.size(), 0);
        push_word(8'h78);
        step(1);
        check_val("f5_after_new", on0, 1);
        check_val("f5_after_data", od0, 8'h78);
        step(6);

        // asynchronous reset during HOLD with 4 words queued
        for (int i = 0; i < 5; i++) push_word(8'(8'h81 + i));
        check_val("ar_count_pre", cnt0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_count0", cnt0, 0);
        check_val("ar_count1", cnt1, 0);
        check_val("ar_empty0", empty0, 1);
        check_val("ar_full0", full0, 0);
        check_val("ar_new0", on0, 0);
        check_val("ar_data0", od0, 0);
        check_val("ar_data1", od1, 0);
        check_val("ar_ovf1", ovf1, 0);
        #3;
        rst_n = 1'b1;
        push_word(8'hC3);
        step(1);
        check_val("ar_post_new0", on0, 1);
        check_val("ar_post_data0", od0, 8'hC3);
        check_val("ar_post_data1", od1, 8'hC3);
        step(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tx_link_fifo

// File: doc/tx_link_fifo.md
TX_LINK_FIFO -- requirements
Module: tx_link_fifo

Interface
REQ-001 Parameter WIDTH, default 8, payload bits per word.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, >=2.
REQ-003 Parameter HOLDOFF, default 4, cycles (>=1) during which out_busy is ignored after each send, covering the consumer's busy-synchroniser latency.
REQ-004 Parameter OVF_MODE, default 0; 0 = drop newest on full, 1 = overwrite oldest on full.
REQ-005 clk_dot4x  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_data  in  WIDTH  word to enqueue.
REQ-008 in_new  in  1  one-cycle enqueue strobe.
REQ-009 flush  in  1  synchronous discard of all queued words.
REQ-010 out_busy  in  1  consumer busy; level.
REQ-011 out_data  out  WIDTH  registered word presented to consumer.
REQ-012 out_new  out  1  registered one-cycle strobe; out_data is valid while high.
REQ-013 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 full / empty  out  1 each  count==DEPTH / count==0.
REQ-015 overflow  out  1  sticky flag: a word was lost.
REQ-016 ovf_clear  in  1  clears overflow.

Function
REQ-017 Storage: circular buffer, head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count tracked separately.
REQ-018 FSM states: IDLE, SEND, HOLD.
REQ-019 IDLE -> SEND at an edge where empty==0 and out_busy==0; that edge pops the head into out_data.
REQ-020 SEND: out_new=1 for exactly one cycle; next state HOLD; holdoff counter loads HOLDOFF-1.
REQ-021 HOLD: counter decrements each cycle; out_busy ignored; at zero -> IDLE.
REQ-022 Minimum spacing between out_new pulses is HOLDOFF+1 cycles.
REQ-023 Latency: in_new sampled at edge k into an empty FIFO, FSM in IDLE, out_busy low -> out_new high between edges k+1 and k+2.
REQ-024 Words are delivered in enqueue order; out_data holds its value until the next pop.
REQ-025 Push and pop at the same edge are both honoured; count is unchanged; no overflow, including when full.
REQ-026 Push when full with no pop: OVF_MODE=0 discards in_data; OVF_MODE=1 advances head, writes tail, and leaves count at DEPTH; both cases set overflow.
REQ-027 In OVF_MODE=1, overwrite coincident with a pop: the pop takes the current head first; count stays DEPTH-1+1.
REQ-028 flush: head=tail, count=0, FSM->IDLE, out_new=0 at the next edge; flush beats in_new in the same cycle; overflow unaffected.
REQ-029 flush during HOLD aborts holdoff.
REQ-030 overflow set and ovf_clear in the same cycle: set wins.
REQ-031 out_busy rising while in IDLE with data queued blocks the send; no timeout.

Reset
REQ-032 rst_n low: out_data=0, out_new=0, count=0, empty=1, full=0, overflow=0, pointers=0, FSM=IDLE, holdoff counter=0.
REQ-033 Reset mid-SEND/HOLD truncates out_new immediately; the queued words are lost.
REQ-034 After rst_n deasserts, the first push is accepted on the first edge.

Structure
REQ-035 FSM state encoding and the OVF_MODE constants live in the shared package (link_pkg).
REQ-036 One sub-module, link_fifo_mem (WIDTH x DEPTH storage, synchronous write, combinational read of head), is permitted; all control stays in tx_link_fifo.

Verification
REQ-037 Defaults; push 0xA5 into an empty FIFO, busy=0 -> out_new at k+1, out_data=0xA5, count back to 0.
REQ-038 Push 3 words back-to-back, busy=0 -> out_new pulses exactly 5 cycles apart, order preserved.
REQ-039 Hold busy=1, push 17 words -> count=16, overflow=1; release busy -> words 0..15 emerge with OVF_MODE=0, words 1..16 with OVF_MODE=1.
REQ-040 Full FIFO, push and pop on the same edge -> count stays 16, overflow=0.
REQ-041 Queue 5 words, assert flush with in_new in the same cycle -> count=0, no out_new, flushed word absent.
REQ-042 Pull rst_n low during HOLD with 4 words queued -> all outputs at reset values asynchronously; next push delivered normally.
